// File: rtl/control_sequencer_if.sv
// Control bus between the SAP-1.5 microsequencer and the datapath.
// The sequencer (master) consumes the IR opcode and flags and produces
// the one-cycle control strobes; the datapath (slave) does the opposite.
interface control_sequencer_if #(
    parameter int OPCODE_WIDTH = 4
);
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    flag_carry;
    logic                    flag_zero;

    logic                    pc_enable;
    logic                    pc_load;
    logic                    pc_oe;
    logic                    mar_load;
    logic                    ram_oe;
    logic                    ram_we;
    logic                    ir_load;
    logic                    ir_oe;
    logic                    a_load;
    logic                    a_oe;
    logic                    b_load;
    logic                    alu_oe;
    logic                    alu_sub;
    logic                    flags_load;
    logic                    out_load;
    logic                    halt;
    logic [2:0]              step;
    logic                    instr_done;

    modport master (
        input  opcode, flag_carry, flag_zero,
        output pc_enable, pc_load, pc_oe, mar_load, ram_oe, ram_we,
               ir_load, ir_oe, a_load, a_oe, b_load, alu_oe, alu_sub,
               flags_load, out_load, halt, step, instr_done
    );

    modport slave (
        output opcode, flag_carry, flag_zero,
        input  pc_enable, pc_load, pc_oe, mar_load, ram_oe, ram_we,
               ir_load, ir_oe, a_load, a_oe, b_load, alu_oe, alu_sub,
               flags_load, out_load, halt, step, instr_done
    );
endinterface

// File: rtl/control_sequencer.sv
// SAP-1.5 microsequencer: walks fetch (T0-T1) and execute (T2-T4)
// microsteps and decodes step/opcode/flags into one-cycle control strobes.
// Strobes are a combinational decode of the registered step so that every
// microstep lasts exactly one clock; reset and halt gate them to zero.
module control_sequencer #(
    parameter int OPCODE_WIDTH    = 4,
    parameter bit SKIP_IDLE_STEPS = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    control_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'('h1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'('h2);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'('h3);
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'('h4);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'('h5);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'('h6);
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'('h7);
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'('h8);
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'('hE);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'('hF);

    step_t step_q;
    step_t last_step;
    logic  halt_q;
    logic  is_last;
    logic  run;

    // Final active microstep of the instruction currently in the IR
    always_comb begin
        last_step = T2;
        case (bus.opcode)
            OP_LDA, OP_STA: last_step = T3;
            OP_ADD, OP_SUB: last_step = T4;
            default:        last_step = T2;
        endcase
    end

    // Without step skipping every instruction occupies T0..T4 and ends in T4
    assign is_last = SKIP_IDLE_STEPS ? (step_q == last_step) : (step_q == T4);
    assign run     = !reset && !halt_q;

    assign bus.step       = step_q;
    assign bus.halt       = halt_q && !reset;
    assign bus.instr_done = run && is_last;

    // Microcode decode: fetch is common, execute depends on opcode and flags
    always_comb begin
        bus.pc_enable  = 1'b0;
        bus.pc_load    = 1'b0;
        bus.pc_oe      = 1'b0;
        bus.mar_load   = 1'b0;
        bus.ram_oe     = 1'b0;
        bus.ram_we     = 1'b0;
        bus.ir_load    = 1'b0;
        bus.ir_oe      = 1'b0;
        bus.a_load     = 1'b0;
        bus.a_oe       = 1'b0;
        bus.b_load     = 1'b0;
        bus.alu_oe     = 1'b0;
        bus.alu_sub    = 1'b0;
        bus.flags_load = 1'b0;
        bus.out_load   = 1'b0;
        if (run) begin
            case (step_q)
                T0: begin
                    bus.pc_oe    = 1'b1;
                    bus.mar_load = 1'b1;
                end
                T1: begin
                    bus.ram_oe    = 1'b1;
                    bus.ir_load   = 1'b1;
                    bus.pc_enable = 1'b1;
                end
                default: begin
                    case (bus.opcode)
                        OP_LDA: begin
                            if (step_q == T2) begin
                                bus.ir_oe    = 1'b1;
                                bus.mar_load = 1'b1;
                            end else if (step_q == T3) begin
                                bus.ram_oe = 1'b1;
                                bus.a_load = 1'b1;
                            end
                        end
                        OP_ADD, OP_SUB: begin
                            if (step_q == T2) begin
                                bus.ir_oe    = 1'b1;
                                bus.mar_load = 1'b1;
                            end else if (step_q == T3) begin
                                bus.ram_oe = 1'b1;
                                bus.b_load = 1'b1;
                            end else if (step_q == T4) begin
                                bus.alu_oe     = 1'b1;
                                bus.a_load     = 1'b1;
                                bus.flags_load = 1'b1;
                                bus.alu_sub    = (bus.opcode == OP_SUB);
                            end
                        end
                        OP_STA: begin
                            if (step_q == T2) begin
                                bus.ir_oe    = 1'b1;
                                bus.mar_load = 1'b1;
                            end else if (step_q == T3) begin
                                bus.a_oe   = 1'b1;
                                bus.ram_we = 1'b1;
                            end
                        end
                        OP_LDI: begin
                            if (step_q == T2) begin
                                bus.ir_oe  = 1'b1;
                                bus.a_load = 1'b1;
                            end
                        end
                        OP_JMP: begin
                            if (step_q == T2) begin
                                bus.ir_oe   = 1'b1;
                                bus.pc_load = 1'b1;
                            end
                        end
                        OP_JC: begin
                            if (step_q == T2 && bus.flag_carry) begin
                                bus.ir_oe   = 1'b1;
                                bus.pc_load = 1'b1;
                            end
                        end
                        OP_JZ: begin
                            if (step_q == T2 && bus.flag_zero) begin
                                bus.ir_oe   = 1'b1;
                                bus.pc_load = 1'b1;
                            end
                        end
                        OP_OUT: begin
                            if (step_q == T2) begin
                                bus.a_oe     = 1'b1;
                                bus.out_load = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            endcase
        end
    end

    // Step counter and sticky halt; HLT freezes the sequencer at T0 until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= T0;
            halt_q <= 1'b0;
        end else if (halt_q) begin
            step_q <= T0;
        end else if (bus.opcode == OP_HLT && step_q == T2) begin
            halt_q <= 1'b1;
            step_q <= T0;
        end else if (is_last) begin
            step_q <= T0;
        end else begin
            step_q <= step_t'(3'(step_q + 3'd1));
        end
    end

endmodule
